// File: rtl/gyro_pkg.sv
// Shared types, default dimensions and arithmetic helpers for the gyro
// sample conditioning path.
package gyro_pkg;

    // Top-level operating mode: calibrating offsets or filtering samples.
    typedef enum logic {
        RUN = 1'b0,
        CAL = 1'b1
    } state_e;

    localparam int DEFAULT_CHANNELS = 3;
    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_AVG_LOG2 = 3;
    localparam int DEFAULT_CAL_LOG2 = 4;

    // a - b clamped to the signed range of a w-bit word; the difference is
    // formed wide enough that it can never wrap before the clamp.
    function automatic longint sat_sub(input longint a, input longint b, input int w);
        longint diff;
        longint max_v;
        longint min_v;
        diff  = a - b;
        max_v = (longint'(1) <<< (w - 1)) - 1;
        min_v = -(longint'(1) <<< (w - 1));
        if (diff > max_v) begin
            return max_v;
        end else if (diff < min_v) begin
            return min_v;
        end
        return diff;
    endfunction

endpackage

// File: rtl/gyro_avg_channel.sv
// One channel of the moving-average filter: a ring buffer of the last
// 2^AVG_LOG2 corrected samples and their running sum. The write pointer is
// shared across channels and owned by the parent.
module gyro_avg_channel #(
    parameter int WIDTH    = 16,
    parameter int AVG_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [AVG_LOG2-1:0]     ptr,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] avg_next
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = WIDTH + AVG_LOG2;

    logic signed [WIDTH-1:0] ring_q [DEPTH];
    logic signed [WIDTH-1:0] ring_d [DEPTH];
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_upd;

    // Sum and average that result if din replaces the oldest entry at ptr.
    always_comb begin
        sum_upd  = sum_q - SUM_W'(ring_q[ptr]) + SUM_W'(din);
        avg_next = WIDTH'(sum_upd >>> AVG_LOG2);
    end

    // Next history: wiped on clear, otherwise oldest slot overwritten on write.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned, which is what keeps this block from inferring latches.
        ring_d = ring_q;
        sum_d  = sum_q;
        if (clear) begin
            ring_d = '{default: '0};
            sum_d  = '0;
        end else if (wr_en) begin
            ring_d[ptr] = din;
            sum_d       = sum_upd;
        end
    end

    // History and running sum registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the ring is reset like any other flop because the running sum
        // assumes all empty slots hold zero during warm-up; non-blocking
        // assignments keep every register updating from pre-edge values.
        if (!rst) begin
            ring_q <= '{default: '0};
            sum_q  <= '0;
        end else begin
            ring_q <= ring_d;
            sum_q  <= sum_d;
        end
    end

endmodule

// File: rtl/gyro_sample_filter.sv
// Per-axis conditioning between the gyro SPI controller and its consumers:
// zero-rate offset calibration, saturating offset removal, a moving average
// per channel, and a channel-selected word for the LED bank.
module gyro_sample_filter
    import gyro_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int AVG_LOG2 = DEFAULT_AVG_LOG2,
    parameter int CAL_LOG2 = DEFAULT_CAL_LOG2,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_valid,
    input  logic [CHANNELS*WIDTH-1:0] sample_data,
    input  logic                      cal_start,
    input  logic [SEL_W-1:0]          sel,
    output logic                      filt_valid,
    output logic [CHANNELS*WIDTH-1:0] filt_data,
    output logic [WIDTH-1:0]          sel_data,
    output logic                      cal_busy,
    output logic                      cal_done
);

    localparam int AVG_N = 1 << AVG_LOG2;
    localparam int ACC_W = WIDTH + CAL_LOG2;
    localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(AVG_N);

    state_e                    state_q, state_d;
    logic signed [WIDTH-1:0]   offset_q [CHANNELS];
    logic signed [WIDTH-1:0]   offset_d [CHANNELS];
    logic signed [ACC_W-1:0]   acc_q    [CHANNELS];
    logic signed [ACC_W-1:0]   acc_d    [CHANNELS];
    logic [CAL_LOG2-1:0]       cal_cnt_q, cal_cnt_d;
    logic [AVG_LOG2-1:0]       ptr_q, ptr_d;
    logic [AVG_LOG2:0]         fill_q, fill_d;
    logic                      filt_valid_q, filt_valid_d;
    logic [CHANNELS*WIDTH-1:0] filt_data_q, filt_data_d;
    logic                      cal_busy_q, cal_busy_d;
    logic                      cal_done_q, cal_done_d;

    logic signed [WIDTH-1:0]   raw      [CHANNELS];
    logic signed [WIDTH-1:0]   corr     [CHANNELS];
    logic signed [WIDTH-1:0]   avg_next [CHANNELS];
    logic                      filt_wr;
    logic                      filt_clear;
    int                        sel_idx;

    // Unpack the raw sample and remove the calibrated offset with saturation.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            raw[c]  = sample_data[c*WIDTH +: WIDTH];
            corr[c] = WIDTH'(sat_sub(longint'(raw[c]), longint'(offset_q[c]), WIDTH));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        gyro_avg_channel #(
            .WIDTH    (WIDTH),
            .AVG_LOG2 (AVG_LOG2)
        ) u_avg (
            .clk      (clk),
            .rst      (rst),
            .clear    (filt_clear),
            .wr_en    (filt_wr),
            .ptr      (ptr_q),
            .din      (corr[g]),
            .avg_next (avg_next[g])
        );
    end

    // Mode sequencing, calibration accumulation, fill tracking and output capture.
    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        acc_d        = acc_q;
        cal_cnt_d    = cal_cnt_q;
        ptr_d        = ptr_q;
        fill_d       = fill_q;
        filt_data_d  = filt_data_q;
        filt_valid_d = 1'b0;
        cal_done_d   = 1'b0;
        filt_wr      = 1'b0;
        filt_clear   = 1'b0;

        case (state_q)
            RUN: begin
                if (cal_start) begin
                    // A sample arriving with the request is dropped entirely.
                    state_d   = CAL;
                    cal_cnt_d = '0;
                    acc_d     = '{default: '0};
                end else if (sample_valid) begin
                    filt_wr = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
                    if (fill_d == FILL_FULL) begin
                        filt_valid_d = 1'b1;
                        for (int c = 0; c < CHANNELS; c++) begin
                            filt_data_d[c*WIDTH +: WIDTH] = avg_next[c];
                        end
                    end
                end
            end
            CAL: begin
                if (sample_valid) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        acc_d[c] = acc_q[c] + ACC_W'(raw[c]);
                    end
                    cal_cnt_d = cal_cnt_q + 1'b1;
                    if (cal_cnt_q == '1) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            offset_d[c] = WIDTH'(acc_d[c] >>> CAL_LOG2);
                        end
                        state_d    = RUN;
                        cal_done_d = 1'b1;
                        filt_clear = 1'b1;
                        ptr_d      = '0;
                        fill_d     = '0;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        cal_busy_d = (state_d == CAL);
    end

    // All control and datapath registers of the top level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            offset_q     <= '{default: '0};
            acc_q        <= '{default: '0};
            cal_cnt_q    <= '0;
            ptr_q        <= '0;
            fill_q       <= '0;
            filt_valid_q <= 1'b0;
            filt_data_q  <= '0;
            cal_busy_q   <= 1'b0;
            cal_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            acc_q        <= acc_d;
            cal_cnt_q    <= cal_cnt_d;
            ptr_q        <= ptr_d;
            fill_q       <= fill_d;
            filt_valid_q <= filt_valid_d;
            filt_data_q  <= filt_data_d;
            cal_busy_q   <= cal_busy_d;
            cal_done_q   <= cal_done_d;
        end
    end

    // LED word: out-of-range selects fall back to the last channel.
    always_comb begin
        sel_idx  = (int'(sel) >= CHANNELS) ? CHANNELS - 1 : int'(sel);
        sel_data = filt_data_q[sel_idx*WIDTH +: WIDTH];
    end

    assign filt_valid = filt_valid_q;
    assign filt_data  = filt_data_q;
    assign cal_busy   = cal_busy_q;
    assign cal_done   = cal_done_q;

endmodule
